gmii_tx_mac: RTL and testbench

GMII_TX_MAC -- requirements
Module: gmii_tx_mac

---
 rtl/eth_pkg.sv | 23 ++
 rtl/crc32_byte.sv | 21 ++
 rtl/gmii_tx_mac.sv | 176 +++++++++++++++++
 tb/tb_gmii_tx_mac.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit MAC state type.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

   localparam int unsigned PREAMBLE_LEN = 7;
   localparam int unsigned FCS_LEN      = 4;

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StSfd,
      StData,
      StPad,
      StFcs,
      StDrain,
      StIfg
   } tx_state_e;

endpackage

// File: rtl/crc32_byte.sv
// Combinational CRC-32 (reflected) update by one byte; usable by both TX and RX paths.
module crc32_byte
   import eth_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [7:0]  data,
   output logic [31:0] crc_next
);

   function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'h000000, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

   assign crc_next = crc_step(crc, data);

endmodule

// File: rtl/gmii_tx_mac.sv
// GMII transmit MAC: frames an AXI-Stream byte stream with preamble, SFD, zero padding and
// FCS, then enforces the inter-frame gap. All GMII outputs are registered.
module gmii_tx_mac
   import eth_pkg::*;
#(
   parameter int unsigned MIN_FRAME_BYTES = 60,
   parameter int unsigned IFG_BYTES       = 12
) (
   input  logic       clk,
   input  logic       sresetn,
   output logic       axis_i_tready,
   input  logic       axis_i_tvalid,
   input  logic [7:0] axis_i_tdata,
   input  logic       axis_i_tlast,
   output logic [7:0] eth_txd,
   output logic       eth_txen,
   output logic       eth_txer
);

   localparam logic [10:0] MinBytes     = 11'(MIN_FRAME_BYTES);
   localparam logic [15:0] IfgLast      = 16'((IFG_BYTES > 0) ? (IFG_BYTES - 1) : 0);
   localparam logic [2:0]  PreambleLast = 3'(PREAMBLE_LEN - 1);
   localparam logic [2:0]  FcsLast      = 3'(FCS_LEN - 1);

   tx_state_e   state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic [2:0]  phase_q, phase_d;
   logic [15:0] ifg_q, ifg_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  txd_q, txd_d;
   logic        txen_q, txen_d;
   logic        txer_q, txer_d;

   logic [10:0] cnt_inc;
   logic [7:0]  crc_data;
   logic [31:0] crc_next;
   logic [31:0] crc_fin;

   // Byte counter saturates so arbitrarily long frames never wrap back under the pad limit.
   assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : (cnt_q + 11'd1);
   assign crc_data = (state_q == StPad) ? 8'h00 : axis_i_tdata;
   assign crc_fin  = ~crc_q;

   crc32_byte u_crc32_byte (
      .crc      (crc_q),
      .data     (crc_data),
      .crc_next (crc_next)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      phase_d       = phase_q;
      ifg_d         = ifg_q;
      crc_d         = crc_q;
      txd_d         = 8'h00;
      txen_d        = 1'b0;
      txer_d        = 1'b0;
      axis_i_tready = 1'b0;

      case (state_q)
         StIdle: begin
            if (axis_i_tvalid) begin
               txd_d   = PREAMBLE_BYTE;
               txen_d  = 1'b1;
               phase_d = 3'd0;
               cnt_d   = 11'd0;
               crc_d   = CRC32_INIT;
               state_d = StPreamble;
            end
         end

         // Registered outputs lead the state by one cycle, so the last preamble cycle
         // already loads the SFD byte.
         StPreamble: begin
            txen_d = 1'b1;
            if (phase_q == PreambleLast) begin
               txd_d   = SFD_BYTE;
               state_d = StSfd;
            end else begin
               txd_d   = PREAMBLE_BYTE;
               phase_d = phase_q + 3'd1;
            end
         end

         StSfd, StData: begin
            axis_i_tready = 1'b1;
            txen_d        = 1'b1;
            if (axis_i_tvalid) begin
               txd_d = axis_i_tdata;
               cnt_d = cnt_inc;
               crc_d = crc_next;
               if (axis_i_tlast) begin
                  phase_d = 3'd0;
                  state_d = (cnt_inc < MinBytes) ? StPad : StFcs;
               end else begin
                  state_d = StData;
               end
            end else begin
               txer_d  = 1'b1;
               state_d = StDrain;
            end
         end

         StPad: begin
            txen_d = 1'b1;
            cnt_d  = cnt_inc;
            crc_d  = crc_next;
            if (cnt_inc >= MinBytes) begin
               state_d = StFcs;
            end
         end

         StFcs: begin
            txen_d = 1'b1;
            case (phase_q[1:0])
               2'd0:    txd_d = crc_fin[7:0];
               2'd1:    txd_d = crc_fin[15:8];
               2'd2:    txd_d = crc_fin[23:16];
               default: txd_d = crc_fin[31:24];
            endcase
            if (phase_q == FcsLast) begin
               ifg_d   = 16'd0;
               state_d = StIfg;
            end else begin
               phase_d = phase_q + 3'd1;
            end
         end

         StDrain: begin
            axis_i_tready = 1'b1;
            if (axis_i_tvalid && axis_i_tlast) begin
               ifg_d   = 16'd0;
               state_d = StIfg;
            end
         end

         StIfg: begin
            if (ifg_q >= IfgLast) begin
               state_d = StIdle;
            end else begin
               ifg_d = ifg_q + 16'd1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sresetn) begin
         state_q <= StIdle;
         cnt_q   <= 11'd0;
         phase_q <= 3'd0;
         ifg_q   <= 16'd0;
         crc_q   <= 32'd0;
         txd_q   <= 8'h00;
         txen_q  <= 1'b0;
         txer_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         ifg_q   <= ifg_d;
         crc_q   <= crc_d;
         txd_q   <= txd_d;
         txen_q  <= txen_d;
         txer_q  <= txer_d;
      end
   end

   assign eth_txd  = txd_q;
   assign eth_txen = txen_q;
   assign eth_txer = txer_q;

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Bench for gmii_tx_mac: drives frames from a byte queue, logs the GMII side every cycle and
// compares it against wire images built from a byte-level Ethernet framing model.
module tb_gmii_tx_mac;

   localparam int MIN_FRAME_BYTES = 60;
   localparam int IFG_BYTES       = 12;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       gap;
   } src_t;

   logic       clk = 1'b0;
   logic       sresetn = 1'b0;
   logic       axis_i_tready;
   logic       axis_i_tvalid = 1'b0;
   logic [7:0] axis_i_tdata = 8'h00;
   logic       axis_i_tlast = 1'b0;
   logic [7:0] eth_txd;
   logic       eth_txen;
   logic       eth_txer;

   always #4 clk = ~clk;

   gmii_tx_mac #(
      .MIN_FRAME_BYTES (MIN_FRAME_BYTES),
      .IFG_BYTES       (IFG_BYTES)
   ) dut (
      .clk           (clk),
      .sresetn       (sresetn),
      .axis_i_tready (axis_i_tready),
      .axis_i_tvalid (axis_i_tvalid),
      .axis_i_tdata  (axis_i_tdata),
      .axis_i_tlast  (axis_i_tlast),
      .eth_txd       (eth_txd),
      .eth_txen      (eth_txen),
      .eth_txer      (eth_txer)
   );

   src_t       src[$];
   logic [7:0] lg_d[$];
   bit         lg_en[$], lg_er[$], lg_rdy[$], lg_hs[$], lg_vld[$];
   int         fst[$], fln[$];
   int         vectors = 0;
   int         miscompares = 0;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Wire image: preamble, SFD, payload zero-padded to the minimum, CRC-32 LSB first.
   function automatic void expect_wire(input bq_t p, output bq_t w);
      bq_t         body;
      logic [31:0] c;
      body = p;
      while (body.size() < MIN_FRAME_BYTES) body.push_back(8'h00);
      c = 32'hFFFFFFFF;
      foreach (body[i]) begin
         c = c ^ {24'h000000, body[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      w = {};
      for (int k = 0; k < 7; k++) w.push_back(8'h55);
      w.push_back(8'hD5);
      foreach (body[i]) w.push_back(body[i]);
      for (int k = 0; k < 4; k++) w.push_back(c[8*k +: 8]);
   endfunction

   function automatic bq_t rand_bytes(input int n);
      bq_t q;
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic push(input bq_t p, input int gap_at);
      for (int i = 0; i < p.size(); i++) begin
         src.push_back('{data: p[i], last: (i == p.size() - 1), gap: (i == gap_at)});
      end
   endtask

   task automatic drive();
      src_t h;
      bit   gap_now;
      gap_now = 1'b0;
      if (src.size() > 0 && src[0].gap) begin
         gap_now = 1'b1;
         h = src[0];
         h.gap = 1'b0;
         src[0] = h;
      end
      axis_i_tvalid = (src.size() > 0) && !gap_now;
      axis_i_tdata  = (src.size() > 0) ? src[0].data : 8'h00;
      axis_i_tlast  = (src.size() > 0) ? src[0].last : 1'b0;
   endtask

   task automatic tick();
      bit hs;
      @(negedge clk);
      hs = axis_i_tvalid && axis_i_tready;
      lg_d.push_back(eth_txd);
      lg_en.push_back(eth_txen);
      lg_er.push_back(eth_txer);
      lg_rdy.push_back(axis_i_tready);
      lg_hs.push_back(hs);
      lg_vld.push_back(axis_i_tvalid);
      @(posedge clk);
      #1;
      if (hs) void'(src.pop_front());
      drive();
   endtask

   task automatic clear_log();
      lg_d.delete(); lg_en.delete(); lg_er.delete();
      lg_rdy.delete(); lg_hs.delete(); lg_vld.delete();
   endtask

   task automatic run_quiet(input string tag, input int budget);
      int n, quiet;
      n = 0;
      quiet = 0;
      while ((src.size() > 0 || quiet < 80) && n < budget) begin
         tick();
         n++;
         quiet = (src.size() == 0) ? quiet + 1 : 0;
      end
      check({tag, "_finished_in_budget"}, int'(n < budget), 1);
   endtask

   task automatic get_frames();
      int run;
      run = 0;
      fst.delete();
      fln.delete();
      for (int i = 0; i < lg_en.size(); i++) begin
         if (lg_en[i]) begin
            if (run == 0) fst.push_back(i);
            run++;
         end else if (run > 0) begin
            fln.push_back(run);
            run = 0;
         end
      end
      if (run > 0) fln.push_back(run);
   endtask

   task automatic check_frame(input string tag, input int s, input int l, input bq_t w);
      int bad;
      bad = -1;
      check({tag, "_txen_cycles"}, l, w.size());
      for (int i = 0; i < w.size() && i < l; i++) begin
         if (bad < 0 && lg_d[s + i] !== w[i]) bad = i;
      end
      if (l > 0) begin
         if (bad < 0) bad = 0;
         check($sformatf("%s_byte%0d", tag, bad), int'(lg_d[s + bad]), int'(w[bad]));
      end
   endtask

   function automatic int count_er();
      int n;
      n = 0;
      foreach (lg_er[i]) n += int'(lg_er[i]);
      return n;
   endfunction

   function automatic int first_idx(input int from, input bit want_hs);
      for (int i = from; i < lg_hs.size(); i++) begin
         if (want_hs ? lg_hs[i] : lg_vld[i]) return i;
      end
      return -1;
   endfunction

   initial begin
      bq_t p, q, w, wt;
      bq_t fr[4];
      int  c0, u, d, n, hs, cnt, rdy;

      // Reset state
      sresetn = 1'b0;
      drive();
      repeat (3) tick();
      check("rst_txen", int'(lg_en[2]), 0);
      check("rst_txer", int'(lg_er[2]), 0);
      check("rst_txd", int'(lg_d[2]), 0);
      check("rst_tready", int'(lg_rdy[2]), 0);
      sresetn = 1'b1;

      // 60-byte counting frame, first frame after reset, no IFG wait
      clear_log();
      p = {};
      for (int i = 0; i < 60; i++) p.push_back(8'(i));
      push(p, -1);
      drive();
      run_quiet("a", 600);
      get_frames();
      expect_wire(p, w);
      check("a_frames", fst.size(), 1);
      if (fst.size() >= 1) begin
         check_frame("a_frame", fst[0], fln[0], w);
         c0 = first_idx(0, 1'b0);
         check("a_first_txd_latency", fst[0], c0 + 1);
         check("a_first_tready_latency", first_idx(0, 1'b1), c0 + 8);
      end
      check("a_txer_count", count_er(), 0);

      // 1-byte frame padded to minimum
      clear_log();
      p = {8'hAA};
      push(p, -1);
      drive();
      run_quiet("b", 600);
      get_frames();
      expect_wire(p, w);
      check("b_frames", fst.size(), 1);
      if (fst.size() >= 1) check_frame("b_frame", fst[0], fln[0], w);
      check("b_txer_count", count_er(), 0);

      // Two back-to-back 64-byte frames with tvalid continuous
      clear_log();
      p = rand_bytes(64);
      q = rand_bytes(64);
      push(p, -1);
      push(q, -1);
      drive();
      run_quiet("c", 1000);
      get_frames();
      check("c_frames", fst.size(), 2);
      if (fst.size() >= 2) begin
         expect_wire(p, w);
         check_frame("c_frame1", fst[0], fln[0], w);
         expect_wire(q, w);
         check_frame("c_frame2", fst[1], fln[1], w);
         check("c_ifg_low_cycles", fst[1] - (fst[0] + fln[0]), IFG_BYTES);
         check("c_frame2_first_tready", first_idx(fst[0] + fln[0], 1'b1), fst[1] + 7);
      end
      check("c_txer_count", count_er(), 0);

      // 100-byte frame with tvalid dropped at byte 10, then a follow-on frame
      clear_log();
      p = rand_bytes(100);
      q = rand_bytes(20 + int'($urandom_range(60)));
      push(p, 10);
      push(q, -1);
      drive();
      run_quiet("d", 1500);
      get_frames();
      check("d_frames", fst.size(), 2);
      check("d_txer_count", count_er(), 1);
      if (fst.size() >= 2) begin
         expect_wire(p, w);
         wt = w[0:17];
         wt.push_back(8'h00);
         check_frame("d_truncated", fst[0], fln[0], wt);
         u = fst[0] + 18;
         check("d_txer_cycle", int'(lg_er[u]), 1);
         cnt = 0;
         rdy = 0;
         d = u;
         for (int i = u; i < fst[1]; i++) begin
            if (lg_hs[i]) begin
               cnt++;
               d = i;
            end
         end
         for (int i = u; i <= d; i++) rdy += int'(lg_rdy[i]);
         check("d_drained_bytes", cnt, 90);
         check("d_drain_tready_cycles", rdy, d - u + 1);
         n = fst[1] - d - 1;
         check("d_idle_after_drain_in_range", int'(n >= IFG_BYTES && n <= IFG_BYTES + 1), 1);
         expect_wire(q, w);
         check_frame("d_next", fst[1], fln[1], w);
      end

      // Reset pulse at payload byte 20, then an immediate new frame
      clear_log();
      p = rand_bytes(80);
      push(p, -1);
      drive();
      n = 0;
      hs = 0;
      while (hs < 20 && n < 200) begin
         tick();
         n++;
         if (lg_hs[lg_hs.size() - 1]) hs++;
      end
      check("e_reached_byte20", hs, 20);
      sresetn = 1'b0;
      src.delete();
      drive();
      tick();
      sresetn = 1'b1;
      tick();
      check("e_post_reset_txen", int'(lg_en[lg_en.size() - 1]), 0);
      check("e_post_reset_tready", int'(lg_rdy[lg_rdy.size() - 1]), 0);
      q = rand_bytes(30 + int'($urandom_range(40)));
      push(q, -1);
      drive();
      c0 = lg_en.size();
      run_quiet("e", 800);
      get_frames();
      check("e_frames", fst.size(), 2);
      if (fst.size() >= 2) begin
         check("e_truncated_len", fln[0], 7 + 1 + 20);
         check("e_restart_at_once", fst[1], c0 + 1);
         expect_wire(q, w);
         check_frame("e_next", fst[1], fln[1], w);
      end
      check("e_txer_count", count_er(), 0);

      // Random-length back-to-back frames
      clear_log();
      for (int k = 0; k < 4; k++) begin
         fr[k] = rand_bytes(1 + int'($urandom_range(129)));
         push(fr[k], -1);
      end
      drive();
      run_quiet("f", 3000);
      get_frames();
      check("f_frames", fst.size(), 4);
      if (fst.size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            expect_wire(fr[k], w);
            check_frame($sformatf("f_frame%0d", k), fst[k], fln[k], w);
            if (k > 0) begin
               check($sformatf("f_ifg%0d", k), fst[k] - (fst[k-1] + fln[k-1]), IFG_BYTES);
            end
         end
      end
      check("f_txer_count", count_er(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
